// File: rtl/dma_pkg.sv
// Shared widths, step size and FSM encoding for the single-channel DMA engine.
package dma_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  // Remaining-word counter only needs the word-index bits of a byte length.
  localparam int CNT_W      = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/dma_controller.sv
// Word-granular memory-to-accelerator copy engine: one memory read then one
// accelerator write per word, strictly sequential, started by a one-cycle strobe.
module dma_controller
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_transfer,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [ADDR_W-1:0] transfer_length,
  output logic              dma_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              acc_read,
  output logic              acc_write,
  input  logic [DATA_W-1:0] acc_data_in,
  output logic [DATA_W-1:0] acc_data_out
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [CNT_W-1:0]  word_count;

  // Byte length rounds down to whole words; the low two bits are dropped.
  assign word_count = transfer_length[ADDR_W-1:2];

  logic unused_inputs;
  assign unused_inputs = ^{acc_data_in, transfer_length[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      src_ptr_reg   <= src_ptr_next;
      dst_ptr_reg   <= dst_ptr_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_ptr_next   = src_ptr_reg;
    dst_ptr_next   = dst_ptr_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (start_transfer && (word_count != '0)) begin
          src_ptr_next   = src_addr;
          dst_ptr_next   = dest_addr;
          remaining_next = word_count;
          state_next     = READ;
        end
      end
      READ: begin
        state_next = WRITE;
      end
      WRITE: begin
        // Pointers wrap modulo 2^32 and keep any misalignment of the start address.
        src_ptr_next   = src_ptr_reg + ADDR_W'(WORD_BYTES);
        dst_ptr_next   = dst_ptr_reg + ADDR_W'(WORD_BYTES);
        remaining_next = remaining_reg - CNT_W'(1);
        state_next     = (remaining_reg == CNT_W'(1)) ? IDLE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dma_busy     = (state_reg != IDLE);
  assign mem_read     = (state_reg == READ);
  assign acc_write    = (state_reg == WRITE);
  assign mem_addr     = src_ptr_reg;
  assign acc_addr     = dst_ptr_reg;
  assign mem_write    = 1'b0;
  assign mem_data_out = '0;
  assign acc_read     = 1'b0;
  // Read data from the previous cycle's memory access flows straight through.
  assign acc_data_out = (state_reg == WRITE) ? mem_data_in : '0;

endmodule

// File: tb/tb_dma_controller.sv
// Checks dma_controller cycle by cycle against a transfer-level reference model
// using directed scenarios followed by randomized transfers.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_transfer;
  logic [31:0] src_addr, dest_addr, transfer_length;
  logic        dma_busy;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_data_in, mem_data_out;
  logic [31:0] acc_addr;
  logic        acc_read, acc_write;
  logic [31:0] acc_data_in, acc_data_out;

  dma_controller dut (
    .clk             (clk),
    .reset           (reset),
    .start_transfer  (start_transfer),
    .src_addr        (src_addr),
    .dest_addr       (dest_addr),
    .transfer_length (transfer_length),
    .dma_busy        (dma_busy),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .acc_addr        (acc_addr),
    .acc_read        (acc_read),
    .acc_write       (acc_write),
    .acc_data_in     (acc_data_in),
    .acc_data_out    (acc_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a transfer is N words occupying 2N cycles; cycle t of the
  // transfer reads (t even) or writes (t odd) word t/2.
  bit          m_active = 0;
  int unsigned m_t = 0;
  int unsigned m_n = 0;
  logic [31:0] m_src = '0, m_dst = '0;
  logic [31:0] m_idle_src = '0, m_idle_dst = '0;
  int          xfer_id = 0;
  int unsigned tr_busy, tr_reads, tr_writes;

  bit          use_const = 0;
  logic [31:0] const_data = 32'hDEADBEEF;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (use_const) return const_data;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (xfer %0d, t=%0d)", tag, got, exp, xfer_id, m_t);
    end
  endtask

  task automatic step();
    bit          rd_prev;
    logic [31:0] ra_prev;
    bit          ended;
    logic [31:0] e_maddr, e_aaddr, e_data;
    bit          e_rd, e_wr;
    rd_prev = (mem_read === 1'b1);
    ra_prev = mem_addr;
    @(posedge clk);
    ended = 0;
    if (reset) begin
      if (m_active) $display("xfer %0d: reset at cycle %0d of %0d, aborted", xfer_id, m_t + 1, 2 * m_n);
      m_active   = 0;
      m_idle_src = '0;
      m_idle_dst = '0;
    end else if (m_active) begin
      m_t++;
      if (m_t == 2 * m_n) begin
        m_active   = 0;
        m_idle_src = m_src + 32'(4 * m_n);
        m_idle_dst = m_dst + 32'(4 * m_n);
        ended      = 1;
      end
    end else if (start_transfer) begin
      if ((transfer_length >> 2) != 0) begin
        m_active = 1;
        m_t      = 0;
        m_n      = transfer_length >> 2;
        m_src    = src_addr;
        m_dst    = dest_addr;
        xfer_id++;
        tr_busy = 0; tr_reads = 0; tr_writes = 0;
      end else begin
        $display("start with length %0d: zero words, ignored", transfer_length);
      end
    end
    #1;
    mem_data_in = rd_prev ? mem_fn(ra_prev) : $urandom();
    #1;
    e_rd    = m_active && (m_t % 2 == 0);
    e_wr    = m_active && (m_t % 2 == 1);
    e_maddr = m_active ? m_src + 32'(4 * (m_t / 2)) : m_idle_src;
    e_aaddr = m_active ? m_dst + 32'(4 * (m_t / 2)) : m_idle_dst;
    e_data  = e_wr ? mem_fn(e_maddr) : '0;
    check_val("dma_busy",     32'(dma_busy),  32'(m_active));
    check_val("mem_read",     32'(mem_read),  32'(e_rd));
    check_val("acc_write",    32'(acc_write), 32'(e_wr));
    check_val("mem_write",    32'(mem_write), 32'd0);
    check_val("acc_read",     32'(acc_read),  32'd0);
    check_val("mem_addr",     mem_addr,       e_maddr);
    check_val("acc_addr",     acc_addr,       e_aaddr);
    check_val("acc_data_out", acc_data_out,   e_data);
    check_val("mem_data_out", mem_data_out,   32'd0);
    if (ended) begin
      check_val("busy_cycles", 32'(tr_busy),   32'(2 * m_n));
      check_val("read_count",  32'(tr_reads),  32'(m_n));
      check_val("write_count", 32'(tr_writes), 32'(m_n));
      $display("xfer %0d: src 0x%08h dst 0x%08h words %0d busy %0d reads %0d writes %0d",
               xfer_id, m_src, m_dst, m_n, tr_busy, tr_reads, tr_writes);
    end
    if (m_active) begin
      tr_busy   += 32'(dma_busy === 1'b1);
      tr_reads  += 32'(mem_read === 1'b1);
      tr_writes += 32'(acc_write === 1'b1);
    end
    start_transfer = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] len);
    src_addr        = s;
    dest_addr       = d;
    transfer_length = len;
    start_transfer  = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && m_active; i++) step();
    check_val("idle_timeout", 32'(m_active), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start_transfer = 1'b0;
    src_addr = '0; dest_addr = '0; transfer_length = '0;
    mem_data_in = '0; acc_data_in = $urandom();
    step();
    reset = 1'b1;
    step();
    step();

    // Basic block with constant memory data.
    use_const = 1;
    launch(32'h0, 32'h1000, 32'h40);
    wait_idle(100);
    use_const = 0;
    step();

    // Zero and short lengths.
    launch(32'h100, 32'h2000, 32'd0); step(); step();
    launch(32'h100, 32'h2000, 32'd3); step(); step();
    launch(32'h100, 32'h2000, 32'd6);
    wait_idle(20); step();

    // Start while busy is ignored.
    launch(32'h200, 32'h3000, 32'h40);
    for (int i = 0; i < 6; i++) step();
    launch(32'h500, 32'h7000, 32'h8);
    src_addr = $urandom(); dest_addr = $urandom(); transfer_length = $urandom();
    wait_idle(100); step();

    // Reset during word 5 of a 16-word transfer, then a fresh start.
    launch(32'h400, 32'h4000, 32'h40);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step(); step();
    launch(32'h600, 32'h5000, 32'h10);
    wait_idle(40); step();

    // Address wrap.
    launch(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd8);
    wait_idle(20);

    // Back-to-back: start in the first idle cycle after completion.
    launch(32'h800, 32'h9000, 32'h0C);
    wait_idle(20);
    launch(32'hA00, 32'hB000, 32'h14);
    wait_idle(30); step();

    // Randomized transfers with stray starts, changing inputs and occasional resets.
    for (int k = 0; k < 30; k++) begin
      logic [31:0] s, d;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
      d = $urandom();
      launch(s, d, 32'($urandom_range(0, 60)));
      for (int i = 0; i < 300 && m_active; i++) begin
        src_addr = $urandom(); dest_addr = $urandom(); transfer_length = $urandom();
        if ($urandom_range(0, 5) == 0) start_transfer = 1'b1;
        if ($urandom_range(0, 60) == 0) reset = 1'b1;
        step();
      end
      check_val("idle_timeout", 32'(m_active), 32'd0);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
# dma_controller

Single-channel, word-granular DMA engine that copies a block of 32-bit words from system memory to the accelerator's local address space. It sits between the SoC memory port and the ML accelerator and is started by a one-cycle command from the host-side control logic. Transfers are strictly sequential: one memory read followed by one accelerator write per word.

## Interface
Parameters: none (bus and data widths fixed at 32).

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start_transfer  in  1  command strobe, sampled only in IDLE
- src_addr  in  32  memory byte address of first word
- dest_addr  in  32  accelerator byte address of first word
- transfer_length  in  32  transfer size in bytes
- dma_busy  out  1  high while a transfer is in progress
- mem_addr  out  32  memory byte address (source pointer)
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe; tied 0
- mem_data_in  in  32  memory read data, valid the cycle after mem_read
- mem_data_out  out  32  memory write data; tied 0
- acc_addr  out  32  accelerator byte address (destination pointer)
- acc_read  out  1  accelerator read strobe; tied 0
- acc_write  out  1  accelerator write strobe
- acc_data_in  in  32  accelerator read data; unused
- acc_data_out  out  32  accelerator write data

## Operation
- Word count N = transfer_length[31:2]; bits [1:0] ignored (round down).
- FSM states: IDLE, READ, WRITE.
- IDLE: start_transfer=1 and N≠0 → latch src_ptr=src_addr, dst_ptr=dest_addr, remaining=N; go to READ. N=0: stay in IDLE, no busy, no strobes.
- READ: mem_read=1, mem_addr=src_ptr → WRITE.
- WRITE: acc_write=1, acc_addr=dst_ptr, acc_data_out=mem_data_in. src_ptr+=4, dst_ptr+=4, remaining-=1. Go to IDLE if remaining was 1, else to READ.
- dma_busy = (state≠IDLE).
- mem_addr/acc_addr continuously reflect src_ptr/dst_ptr. After completion they hold the post-increment values.
- acc_data_out = 0 outside WRITE.
- Pointer arithmetic is modulo 2^32 (wraps silently). Unaligned addresses are used as-is, still stepping by 4.
- start_transfer while busy is ignored; no queuing.
- Input ports other than start_transfer are sampled only on the accepting edge.

## Timing
- Reset values: state IDLE, dma_busy 0, all strobes 0, mem_addr 0, acc_addr 0, acc_data_out 0, mem_data_out 0, remaining 0.
- Reset mid-transfer: next edge returns to IDLE with reset values. No further strobes are issued.
- Start is accepted on edge k. READ occupies cycle k+1 and WRITE cycle k+2, so each word takes 2 cycles.
- dma_busy is high for exactly 2N cycles. It falls on the edge that ends the last WRITE.
- A new start can be accepted in the first IDLE cycle after completion.
- Memory is assumed to be a fixed 1-cycle synchronous read: data for the READ-cycle address is present on mem_data_in during the following WRITE cycle. There are no wait states or ready signals.
- Outputs are decoded combinationally from registered state and pointers. No input-to-output combinational path exists except mem_data_in→acc_data_out in WRITE.

## Structure
- Package dma_pkg:
  - state enum (IDLE, READ, WRITE)
  - WORD_BYTES=4
  - ADDR_W=32, DATA_W=32
- Single module with no sub-modules; the FSM and three counters are small enough to keep flat.

## Test plan
- **Basic block:** src 0x0, dest 0x1000, length 0x40, mem_data_in 0xDEADBEEF, 1-cycle start.
  - Required: 16 mem reads at 0x0…0x3C, each followed next cycle by an acc write of 0xDEADBEEF at 0x1000…0x103C.
  - Required: dma_busy high exactly 32 cycles; mem_write and acc_read never assert.
- **Zero/short length:**
  - Length 0: no busy, no strobes.
  - Length 3: no busy, no strobes.
  - Length 6: exactly one read at src and one write at dest, busy 2 cycles.
- **Start while busy:** second start with src 0x500 pulsed mid-transfer → ignored; original sequence completes unchanged.
- **Reset mid-transfer:** assert reset during word 5 of a 16-word transfer.
  - Required next edge: busy 0, addresses 0, no strobes.
  - Required after reset: a fresh start works normally.
- **Address wrap:** src 0xFFFFFFFC, dest 0xFFFFFFFC, length 8 → reads at 0xFFFFFFFC then 0x00000000; writes at the same two addresses.
- **Back-to-back:** start reasserted in the first IDLE cycle after completion → accepted; new transfer begins the next cycle.
